tcdm_banks_pipe_wrap: RTL



---
 rtl/tcdm_banks_pipe_wrap.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tcdm_banks_pipe_wrap.sv
// tcdm_banks_pipe_wrap: NB_BANKS independent single-port SRAM banks with a 1- or 2-cycle read pipeline.
// Ports: clk_i / rst_ni     clock, asynchronous active-low reset
//        pwdn_i             power-down, blocks every grant (in-flight reads still complete)
//        test_mode_i        DFT, forces the init FSM to READY
//        req_i, add_i, wen_i, data_i, be_i, id_i   per-bank request (wen_i = 1 read, 0 write)
//        gnt_o              combinational per-bank grant
//        r_valid_o, r_data_o, r_id_o               per-bank read response (data/id hold between responses)
//        init_done_o        banks ready for traffic
// Build option: define TCDM_BANK_INIT_EN to zero every bank after reset before traffic is granted.
module tcdm_banks_pipe_wrap #(
    parameter int BANK_SIZE    = 256,
    parameter int NB_BANKS     = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int ID_WIDTH     = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             pwdn_i,
    input  logic                             test_mode_i,
    input  logic [NB_BANKS-1:0]              req_i,
    input  logic [NB_BANKS*32-1:0]           add_i,
    input  logic [NB_BANKS-1:0]              wen_i,
    input  logic [NB_BANKS*DATA_WIDTH-1:0]   data_i,
    input  logic [NB_BANKS*DATA_WIDTH/8-1:0] be_i,
    input  logic [NB_BANKS*ID_WIDTH-1:0]     id_i,
    output logic [NB_BANKS-1:0]              gnt_o,
    output logic [NB_BANKS-1:0]              r_valid_o,
    output logic [NB_BANKS*DATA_WIDTH-1:0]   r_data_o,
    output logic [NB_BANKS*ID_WIDTH-1:0]     r_id_o,
    output logic                             init_done_o
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int LSB  = $clog2(BE_W);
    localparam int AW   = $clog2(BANK_SIZE);

    logic          w_ready;
    logic          w_init_we;
    logic [AW-1:0] w_init_addr;
    logic          w_unused;

    // only the word-index bits of each address are used
    assign w_unused = ^{add_i, test_mode_i};

`ifdef TCDM_BANK_INIT_EN
    typedef enum logic {INIT, READY} state_t;
    state_t        r_state;
    logic [AW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else if (test_mode_i) begin
            r_state <= READY;
        end else if (r_state == INIT && !pwdn_i) begin
            r_cnt <= r_cnt + AW'(1);
            if (r_cnt == AW'(BANK_SIZE - 1)) r_state <= READY;
        end
    end

    // test mode overrides the FSM combinationally so DFT sees a ready array at once
    assign w_ready     = (r_state == READY) || test_mode_i;
    assign w_init_we   = (r_state == INIT) && !test_mode_i && !pwdn_i;
    assign w_init_addr = r_cnt;
`else
    assign w_ready     = 1'b1;
    assign w_init_we   = 1'b0;
    assign w_init_addr = '0;
`endif

    assign init_done_o = w_ready;

    genvar i;
    for (i = 0; i < NB_BANKS; i++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [BANK_SIZE];
        logic [AW-1:0]         w_addr;
        logic                  w_gnt;
        logic                  w_rd;
        logic                  r_v1;
        logic [DATA_WIDTH-1:0] r_d1;
        logic [ID_WIDTH-1:0]   r_id1;

        assign w_addr   = add_i[i*32+LSB +: AW];
        assign w_gnt    = req_i[i] & w_ready & ~pwdn_i;
        assign w_rd     = w_gnt & wen_i[i];
        assign gnt_o[i] = w_gnt;

        // array contents are never reset; the init FSM zeroes them when compiled in
        always_ff @(posedge clk_i) begin
            if (w_init_we)
                r_mem[w_init_addr] <= '0;
            else if (w_gnt && !wen_i[i])
                for (int b = 0; b < BE_W; b++)
                    if (be_i[i*BE_W+b]) r_mem[w_addr][b*8 +: 8] <= data_i[i*DATA_WIDTH+b*8 +: 8];
        end

        // data/id only load on a read so they hold the last response
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_v1  <= 1'b0;
                r_d1  <= '0;
                r_id1 <= '0;
            end else begin
                r_v1 <= w_rd;
                if (w_rd) begin
                    r_d1  <= r_mem[w_addr];
                    r_id1 <= id_i[i*ID_WIDTH +: ID_WIDTH];
                end
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_v2;
            logic [DATA_WIDTH-1:0] r_d2;
            logic [ID_WIDTH-1:0]   r_id2;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_v2  <= 1'b0;
                    r_d2  <= '0;
                    r_id2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2  <= r_d1;
                        r_id2 <= r_id1;
                    end
                end
            end

            assign r_valid_o[i]                         = r_v2;
            assign r_data_o[i*DATA_WIDTH +: DATA_WIDTH] = r_d2;
            assign r_id_o[i*ID_WIDTH +: ID_WIDTH]       = r_id2;
        end else begin : g_lat1
            assign r_valid_o[i]                         = r_v1;
            assign r_data_o[i*DATA_WIDTH +: DATA_WIDTH] = r_d1;
            assign r_id_o[i*ID_WIDTH +: ID_WIDTH]       = r_id1;
        end
    end
endmodule
